// File: rtl/uart_tx_sequencer_if.sv
// Handshake and shift-register strobe bundle for the UART transmit sequencer.
// The master side offers bytes; the slave side (the sequencer) builds and drives frames.
interface uart_tx_sequencer_if;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] sr_d_in;
  logic        sr_load;
  logic        sr_shift;
  logic        busy;
  logic        done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  sr_d_in,
    input  sr_load,
    input  sr_shift,
    input  busy,
    input  done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output sr_d_in,
    output sr_load,
    output sr_shift,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts a byte, builds a 12-bit frame
// {stop, stop, parity, data[7:0], start} and strobes the downstream shift
// register so the frame leaves LSB-first at CLKS_PER_BIT clocks per bit.
// Every output is registered; the output process computes next-cycle values
// from the next state so strobes line up exactly with the frame timing.
module uart_tx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input logic                 clock_i,
  input logic                 reset_i,
  uart_tx_sequencer_if.slave  bus_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  // A strobe registered while the counter sits here appears exactly on a bit boundary.
  localparam logic [CntW-1:0] CntPreStrobe = CntW'(CLKS_PER_BIT - 2);
  localparam logic [3:0] LastIdx = 4'd11;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;

  logic        tx_ready_q, tx_ready_d;
  logic [11:0] sr_d_in_q, sr_d_in_d;
  logic        sr_load_q, sr_load_d;
  logic        sr_shift_q, sr_shift_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        parity;
  logic [11:0] frame;

  assign accept = (state_q == StIdle) && bus_if.tx_valid && tx_ready_q;
  assign parity = (^bus_if.tx_data) ^ PARITY_ODD;
  assign frame  = {2'b11, parity, bus_if.tx_data, 1'b0};

  // State register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one LOAD cycle, then SHIFT until the done cycle has been shown.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (done_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and counter next values, registered below.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sr_d_in_d  = sr_d_in_q;
    sr_load_d  = 1'b0;
    sr_shift_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != StIdle);
    tx_ready_d = (state_d == StIdle);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d_in_d = frame;
          sr_load_d = 1'b1;
        end
      end
      StLoad: begin
        cnt_d = '0;
        idx_d = '0;
      end
      StShift: begin
        cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CntPreStrobe) begin
          if (idx_q < LastIdx) begin
            sr_shift_d = 1'b1;
            idx_d      = idx_q + 4'd1;
          end else begin
            // All 11 shifts issued; the stop bit has now held for a full period.
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_ready_q <= 1'b1;
      sr_d_in_q  <= 12'hFFF;
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_ready_q <= tx_ready_d;
      sr_d_in_q  <= sr_d_in_d;
      sr_load_q  <= sr_load_d;
      sr_shift_q <= sr_shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus_if.tx_ready = tx_ready_q;
  assign bus_if.sr_d_in  = sr_d_in_q;
  assign bus_if.sr_load  = sr_load_q;
  assign bus_if.sr_shift = sr_shift_q;
  assign bus_if.busy     = busy_q;
  assign bus_if.done     = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: three instances (C=4 even, C=4 odd, C=2 even),
// each feeding a model of the 12-bit shift register so the serial line is visible.
module tb_uart_tx_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sequencer_if if0 ();
  uart_tx_sequencer_if if1 ();
  uart_tx_sequencer_if if2 ();

  uart_tx_sequencer #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut0 (
    .clock_i(clk), .reset_i(rst), .bus_if(if0)
  );
  uart_tx_sequencer #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut1 (
    .clock_i(clk), .reset_i(rst), .bus_if(if1)
  );
  uart_tx_sequencer #(.CLKS_PER_BIT(2), .PARITY_ODD(1'b0)) dut2 (
    .clock_i(clk), .reset_i(rst), .bus_if(if2)
  );

  logic [7:0]  dat [3];
  logic        vld [3];
  logic        ld  [3];
  logic        sh  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic [11:0] din [3];
  logic [11:0] sr  [3];

  assign if0.tx_data = dat[0];
  assign if1.tx_data = dat[1];
  assign if2.tx_data = dat[2];
  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign ld[0] = if0.sr_load;  assign ld[1] = if1.sr_load;  assign ld[2] = if2.sr_load;
  assign sh[0] = if0.sr_shift; assign sh[1] = if1.sr_shift; assign sh[2] = if2.sr_shift;
  assign rdy[0] = if0.tx_ready; assign rdy[1] = if1.tx_ready; assign rdy[2] = if2.tx_ready;
  assign bsy[0] = if0.busy;    assign bsy[1] = if1.busy;    assign bsy[2] = if2.busy;
  assign dn[0] = if0.done;     assign dn[1] = if1.done;     assign dn[2] = if2.done;
  assign din[0] = if0.sr_d_in; assign din[1] = if1.sr_d_in; assign din[2] = if2.sr_d_in;

  // Shift-register model: preset on reset, parallel load, shift right filling with 1.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rst) sr[u] <= 12'hFFF;
      else if (ld[u]) sr[u] <= din[u];
      else if (sh[u]) sr[u] <= {1'b1, sr[u][11:1]};
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic wait_ready(input int u, input string nm);
    int waited = 0;
    while (rdy[u] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check({nm, " ready before send"}, 32'(rdy[u]), 32'd1);
  endtask

  // Send one byte and check every cycle of the frame against the expected frame.
  task automatic send_frame(input int u, input logic [7:0] d, input logic [11:0] f,
                            input int c, input string nm);
    logic exp_sh;
    @(negedge clk);
    wait_ready(u, nm);
    if (rdy[u] !== 1'b1) return;
    dat[u] = d;
    vld[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({nm, " load at T"}, 32'(ld[u]), 32'd1);
    check({nm, " sr_d_in"}, 32'(din[u]), 32'(f));
    check({nm, " busy at T"}, 32'(bsy[u]), 32'd1);
    check({nm, " ready low at T"}, 32'(rdy[u]), 32'd0);
    vld[u] = 1'b0;
    for (int j = 1; j <= 12 * c + 1; j++) begin
      @(negedge clk);
      if (j <= 12 * c) begin
        exp_sh = ((j % c) == 0) && (j < 12 * c);
        check({nm, " shift"}, 32'(sh[u]), 32'(exp_sh));
        check({nm, " tx"}, 32'(sr[u][0]), 32'(f[(j - 1) / c]));
        check({nm, " done"}, 32'(dn[u]), 32'((j == 12 * c) ? 1 : 0));
        check({nm, " busy"}, 32'(bsy[u]), 32'd1);
        check({nm, " no load"}, 32'(ld[u]), 32'd0);
        check({nm, " ready low"}, 32'(rdy[u]), 32'd0);
        check({nm, " din held"}, 32'(din[u]), 32'(f));
      end else begin
        check({nm, " ready after"}, 32'(rdy[u]), 32'd1);
        check({nm, " busy after"}, 32'(bsy[u]), 32'd0);
        check({nm, " done after"}, 32'(dn[u]), 32'd0);
        check({nm, " tx idle"}, 32'(sr[u][0]), 32'd1);
      end
    end
  endtask

  typedef struct {
    int          unit;
    logic [7:0]  data;
    logic [11:0] frame;
    int          c;
    string       name;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2, n, nsh;
    for (int u = 0; u < 3; u++) begin
      dat[u] = 8'h00;
      vld[u] = 1'b0;
    end

    vecs[0] = '{0, 8'hA5, 12'hD4A, 4, "A5 even"};
    vecs[1] = '{1, 8'hA5, 12'hF4A, 4, "A5 odd"};
    vecs[2] = '{0, 8'h01, 12'hE02, 4, "01 even"};
    vecs[3] = '{2, 8'hFF, 12'hDFE, 2, "FF C2"};

    // Reset for three cycles, then check reset values on every instance.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      check("rst ready", 32'(rdy[u]), 32'd1);
      check("rst busy", 32'(bsy[u]), 32'd0);
      check("rst load", 32'(ld[u]), 32'd0);
      check("rst shift", 32'(sh[u]), 32'd0);
      check("rst done", 32'(dn[u]), 32'd0);
      check("rst din", 32'(din[u]), 32'h0000_0FFF);
      check("rst tx", 32'(sr[u][0]), 32'd1);
    end

    for (int i = 0; i < 4; i++)
      send_frame(vecs[i].unit, vecs[i].data, vecs[i].frame, vecs[i].c, vecs[i].name);

    // Back-to-back: tx_valid held, data swapped mid-frame.
    @(negedge clk);
    wait_ready(0, "b2b");
    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    t1 = -1;
    t2 = -1;
    n = 0;
    for (int i = 0; i < 150 && t2 < 0; i++) begin
      @(negedge clk);
      n++;
      if (ld[0]) begin
        if (t1 < 0) begin
          t1 = n;
          check("b2b first din", 32'(din[0]), 32'h0000_0C78);
          dat[0] = 8'hC3;
        end else begin
          t2 = n;
          check("b2b second din", 32'(din[0]), 32'h0000_0D86);
          vld[0] = 1'b0;
        end
      end else if (t1 >= 0) begin
        if (n - t1 <= 48) begin
          check("b2b ready low", 32'(rdy[0]), 32'd0);
          check("b2b din held", 32'(din[0]), 32'h0000_0C78);
        end
        if (n - t1 == 48) check("b2b done", 32'(dn[0]), 32'd1);
        if (n - t1 == 49) check("b2b ready back", 32'(rdy[0]), 32'd1);
      end
    end
    vld[0] = 1'b0;
    check("b2b load gap", 32'(t2 - t1), 32'd50);

    // Reset after the fifth shift of a frame.
    @(negedge clk);
    wait_ready(0, "midrst");
    dat[0] = 8'h5A;
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    nsh = 0;
    for (int i = 0; i < 100 && nsh < 5; i++) begin
      @(negedge clk);
      if (sh[0]) nsh++;
    end
    check("midrst shifts seen", 32'(nsh), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst ready", 32'(rdy[0]), 32'd1);
    check("midrst busy", 32'(bsy[0]), 32'd0);
    check("midrst load", 32'(ld[0]), 32'd0);
    check("midrst shift", 32'(sh[0]), 32'd0);
    check("midrst done", 32'(dn[0]), 32'd0);
    check("midrst tx", 32'(sr[0][0]), 32'd1);
    @(negedge clk);
    check("midrst no late done", 32'(dn[0]), 32'd0);
    check("midrst still idle", 32'(bsy[0]), 32'd0);
    send_frame(0, 8'h00, 12'hC00, 4, "00 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
